// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Shares one single-port 32-bit memory between the instruction-fetch port
// (i_*) and the load/store port (d_*) of the rv32 core. Each requester holds
// its request until acknowledged. The arbiter latches the winning request into
// the mem_* registers, holds mem_req until mem_ack, and routes the
// acknowledge plus read data back to the owner in the same cycle as mem_ack.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_req/i_addr              fetch request (always a 32-bit read)
//   i_ack/i_rdata             fetch completion pulse and data
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request
//   d_ack/d_rdata             load/store completion pulse and load data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  latched memory transaction
//   mem_ack/mem_rdata         memory completion pulse and read data
//   busy                      a transaction is in flight
//
// Data requests normally win. To keep fetch from starving, a streak counter
// tracks consecutive data grants taken while a fetch was waiting; once it
// reaches D_STREAK_MAX the next arbitration goes to the fetch port.
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    localparam int CNT_W = (D_STREAK_MAX < 2) ? 1 : $clog2(D_STREAK_MAX + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(D_STREAK_MAX);
    localparam logic [CNT_W-1:0] STREAK_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    logic [1:0]        state_reg,     state_next;
    logic [CNT_W-1:0]  streak_reg,    streak_next;
    logic              mem_we_reg,    mem_we_next;
    logic [3:0]        mem_be_reg,    mem_be_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;

    // Fetch wins only when data is idle or data has used up its streak.
    logic fetch_wins;
    assign fetch_wins = i_req && (!d_req || (streak_reg == STREAK_MAX));

    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        mem_we_next    = mem_we_reg;
        mem_be_next    = mem_be_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (fetch_wins) begin
                    state_next     = ST_BUSY_I;
                    streak_next    = '0;
                    mem_we_next    = 1'b0;
                    mem_be_next    = 4'hF;
                    mem_addr_next  = i_addr;
                    mem_wdata_next = 32'h0;
                end else if (d_req) begin
                    state_next     = ST_BUSY_D;
                    mem_we_next    = d_we;
                    mem_be_next    = d_be;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                    // Only data grants that made a fetch wait extend the streak.
                    if (!i_req) begin
                        streak_next = '0;
                    end else if (streak_reg != STREAK_MAX) begin
                        streak_next = streak_reg + STREAK_ONE;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            streak_reg    <= '0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'h0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 32'h0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            mem_we_reg    <= mem_we_next;
            mem_be_reg    <= mem_be_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    // mem_req/busy come straight from state so an asynchronous reset drops
    // them immediately and no ack can be forwarded for an aborted transfer.
    assign mem_req   = (state_reg != ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign mem_we    = mem_we_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Acks are combinational so zero-wait memory completes in the first
    // mem_req cycle; mem_ack seen in IDLE is dropped here.
    assign i_ack   = (state_reg == ST_BUSY_I) && mem_ack;
    assign d_ack   = (state_reg == ST_BUSY_D) && mem_ack;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
